// File: rtl/shapool_result_collector.sv
// shapool_result_collector: nonce counter, hit capture and hit FIFO between the hash pool and the IO block.
// Optional NONCE_OFFSET_CORRECT_EN: report (nonce - 1) so the host needs no correction.
module shapool_result_collector #(
  parameter int POOL_SIZE         = 2,
  parameter int POOL_SIZE_LOG2    = 1,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_LOG2   = 2,
  parameter int RESULT_DATA_WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   nonce_start,
  input  logic                         run,
  input  logic                         round_done,
  input  logic [POOL_SIZE-1:0]         match_flags,
  input  logic                         result_ack,
  output logic                         shapool_success,
  output logic [RESULT_DATA_WIDTH-1:0] shapool_result,
  output logic                         overflow,
  output logic                         exhausted
);
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  logic                         r_run_q;
  logic [31:0]                  r_nonce;
  logic                         r_exhausted;
  logic                         r_overflow;
  logic [RESULT_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   r_wp;
  logic [FIFO_DEPTH_LOG2-1:0]   r_rp;
  logic [CW-1:0]                r_cnt;
  logic                         w_start;
  logic                         w_round;
  logic                         w_push;
  logic                         w_empty;
  logic                         w_full;
  logic                         w_pop;
  logic                         w_store;
  logic                         w_wrap;
  logic [23:0]                  w_base;
  logic [23:0]                  w_low;
  logic [31:0]                  w_nonce_nxt;
  logic [RESULT_DATA_WIDTH-1:0] w_entry;
  assign w_start = run & ~r_run_q;
  // A round landing on the run rising edge is discarded: the flush wins.
  assign w_round = round_done & run & ~r_exhausted & ~w_start;
  assign w_push  = w_round & |match_flags;
  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == CW'(FIFO_DEPTH);
  assign w_pop   = result_ack & ~w_empty;
  assign w_store = w_push & (~w_full | w_pop);
  assign w_wrap  = r_nonce[23:0] == 24'hFFFFFF;
`ifdef NONCE_OFFSET_CORRECT_EN
  assign w_base = r_nonce[23:0] - 24'd1;
`else
  assign w_base = r_nonce[23:0];
`endif
  // Host expects the top POOL_SIZE_LOG2 bits of the low nonce field cleared.
  assign w_low   = (w_base << POOL_SIZE_LOG2) >> POOL_SIZE_LOG2;
  assign w_entry = {r_nonce[31:24], w_low, 8'(match_flags)};
  assign w_nonce_nxt = w_start ? {nonce_start, 24'h0} :
                       (w_round & ~w_wrap) ? {r_nonce[31:24], r_nonce[23:0] + 24'd1} : r_nonce;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_q     <= 1'b0;
      r_nonce     <= '0;
      r_exhausted <= 1'b0;
      r_overflow  <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
    end else begin
      r_run_q <= run;
      r_nonce <= w_nonce_nxt;
      if (w_start) begin
        r_exhausted <= 1'b0;
        r_overflow  <= 1'b0;
        r_wp        <= '0;
        r_rp        <= '0;
        r_cnt       <= '0;
      end else begin
        if (w_round & w_wrap) r_exhausted <= 1'b1;
        if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
        if (w_store) r_wp <= r_wp + FIFO_DEPTH_LOG2'(1);
        if (w_pop) r_rp <= r_rp + FIFO_DEPTH_LOG2'(1);
        r_cnt <= r_cnt + CW'(w_store) - CW'(w_pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && w_store) r_mem[r_wp] <= w_entry;
  end
  assign shapool_success = ~w_empty;
  assign shapool_result  = w_empty ? '0 : r_mem[r_rp];
  assign overflow        = r_overflow;
  assign exhausted       = r_exhausted;
endmodule

// File: tb/tb_shapool_result_collector.sv
// tb_shapool_result_collector: directed self-checking bench for the shapool result collector.
module tb_shapool_result_collector;
`ifdef NONCE_OFFSET_CORRECT_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  nonce_start = 8'hA5;
  logic        run = 1'b0;
  logic        round_done = 1'b0;
  logic [1:0]  match_flags = 2'b00;
  logic        result_ack = 1'b0;
  logic        shapool_success;
  logic [39:0] shapool_result;
  logic        overflow;
  logic        exhausted;
  int checks = 0;
  int fails = 0;

  shapool_result_collector dut (
    .clk(clk), .reset(reset), .nonce_start(nonce_start), .run(run),
    .round_done(round_done), .match_flags(match_flags), .result_ack(result_ack),
    .shapool_success(shapool_success), .shapool_result(shapool_result),
    .overflow(overflow), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] ent(input logic [23:0] n, input logic [7:0] f);
    logic [23:0] m;
    m = n - 24'(OFS);
    return {8'hA5, 1'b0, m[22:0], f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
  endtask

  task automatic round(input logic [1:0] f, input logic ack);
    round_done = 1'b1;
    match_flags = f;
    result_ack = ack;
    tick();
    round_done = 1'b0;
    match_flags = 2'b00;
    result_ack = 1'b0;
  endtask

  task automatic ack_one();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL reset_success: got %b expected 0", shapool_success); end
    checks++; if (shapool_result !== 40'h0) begin fails++; $display("FAIL reset_result: got %h expected 0", shapool_result); end
    checks++; if ({overflow, exhausted} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {overflow, exhausted}); end
    checks++; if (dut.r_nonce !== 32'h0) begin fails++; $display("FAIL reset_nonce: got %h expected 0", dut.r_nonce); end
  endtask

  task automatic test_nonce_start();
    start_run();
    checks++; if (dut.r_nonce !== 32'hA5000000) begin fails++; $display("FAIL start_nonce: got %h expected a5000000", dut.r_nonce); end
    round(2'b00, 1'b0);
    checks++; if (dut.r_nonce !== 32'hA5000001) begin fails++; $display("FAIL first_round_nonce: got %h expected a5000001", dut.r_nonce); end
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL no_hit_success: got %b expected 0", shapool_success); end
  endtask

  task automatic test_hit();
    logic [39:0] e;
    e = (OFS == 1) ? 40'hA500000102 : 40'hA500000202;
    start_run();
    round(2'b00, 1'b0);
    round(2'b00, 1'b0);
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL hit_pre_success: got %b expected 0", shapool_success); end
    round(2'b10, 1'b0);
    checks++; if (shapool_success !== 1'b1) begin fails++; $display("FAIL hit_success: got %b expected 1", shapool_success); end
    checks++; if (shapool_result !== e) begin fails++; $display("FAIL hit_result: got %h expected %h", shapool_result, e); end
    ack_one();
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL hit_ack_empty: got %b expected 0", shapool_success); end
  endtask

  task automatic test_overflow();
    logic [1:0] fl [5];
    fl = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    start_run();
    for (int i = 0; i < 4; i++) round(fl[i], 1'b0);
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_no_overflow: got %b expected 0", overflow); end
    round(fl[4], 1'b0);
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    checks++; if (dut.r_cnt !== 3'd4) begin fails++; $display("FAIL overflow_count: got %0d expected 4", dut.r_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (shapool_result !== ent(24'(i), {6'b0, fl[i]})) begin fails++; $display("FAIL drain_order[%0d]: got %h expected %h", i, shapool_result, ent(24'(i), {6'b0, fl[i]})); end
      ack_one();
    end
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", shapool_success); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    start_run();
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL restart_clears_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) round(2'b01, 1'b0);
    round(2'b10, 1'b1);
    checks++; if (dut.r_cnt !== 3'd4) begin fails++; $display("FAIL pushpop_count: got %0d expected 4", dut.r_cnt); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL pushpop_overflow: got %b expected 0", overflow); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (shapool_result !== ent(24'(i), 8'h01)) begin fails++; $display("FAIL pushpop_head[%0d]: got %h expected %h", i, shapool_result, ent(24'(i), 8'h01)); end
      ack_one();
    end
    checks++; if (shapool_result !== ent(24'd4, 8'h02)) begin fails++; $display("FAIL pushpop_tail: got %h expected %h", shapool_result, ent(24'd4, 8'h02)); end
    ack_one();
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL pushpop_empty: got %b expected 0", shapool_success); end
  endtask

  task automatic test_exhaust();
    start_run();
    force dut.r_nonce = 32'hA5FFFFFE;
    tick();
    release dut.r_nonce;
    checks++; if (dut.r_nonce !== 32'hA5FFFFFE) begin fails++; $display("FAIL preload_nonce: got %h expected a5fffffe", dut.r_nonce); end
    round(2'b00, 1'b0);
    checks++; if (exhausted !== 1'b0) begin fails++; $display("FAIL exhaust_early: got %b expected 0", exhausted); end
    round(2'b01, 1'b0);
    checks++; if (exhausted !== 1'b1) begin fails++; $display("FAIL exhaust_set: got %b expected 1", exhausted); end
    checks++; if (dut.r_nonce !== 32'hA5FFFFFF) begin fails++; $display("FAIL exhaust_nonce: got %h expected a5ffffff", dut.r_nonce); end
    checks++; if (shapool_result !== ent(24'hFFFFFF, 8'h01)) begin fails++; $display("FAIL exhaust_last_hit: got %h expected %h", shapool_result, ent(24'hFFFFFF, 8'h01)); end
    ack_one();
    round(2'b11, 1'b0);
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL exhaust_ignored: got %b expected 0", shapool_success); end
    checks++; if (dut.r_nonce !== 32'hA5FFFFFF) begin fails++; $display("FAIL exhaust_hold: got %h expected a5ffffff", dut.r_nonce); end
  endtask

  task automatic test_run_halt();
    start_run();
    checks++; if (exhausted !== 1'b0) begin fails++; $display("FAIL restart_clears_exhausted: got %b expected 0", exhausted); end
    round(2'b01, 1'b0);
    round(2'b10, 1'b0);
    run = 1'b0;
    tick();
    round(2'b11, 1'b0);
    checks++; if (dut.r_cnt !== 3'd2) begin fails++; $display("FAIL halt_count: got %0d expected 2", dut.r_cnt); end
    checks++; if (dut.r_nonce !== 32'hA5000002) begin fails++; $display("FAIL halt_nonce: got %h expected a5000002", dut.r_nonce); end
    checks++; if (shapool_result !== ent(24'd0, 8'h01)) begin fails++; $display("FAIL halt_head0: got %h expected %h", shapool_result, ent(24'd0, 8'h01)); end
    ack_one();
    checks++; if (shapool_result !== ent(24'd1, 8'h02)) begin fails++; $display("FAIL halt_head1: got %h expected %h", shapool_result, ent(24'd1, 8'h02)); end
    run = 1'b1;
    tick();
    checks++; if (shapool_success !== 1'b0) begin fails++; $display("FAIL rerun_flush: got %b expected 0", shapool_success); end
    round(2'b01, 1'b0);
    round(2'b10, 1'b0);
    ack_one();
    checks++; if (shapool_success !== 1'b1) begin fails++; $display("FAIL middrain_success: got %b expected 1", shapool_success); end
    reset = 1'b1;
    round(2'b11, 1'b0);
    reset = 1'b0;
    checks++; if ({shapool_success, overflow, exhausted} !== 3'b000) begin fails++; $display("FAIL middrain_reset_flags: got %b expected 000", {shapool_success, overflow, exhausted}); end
    checks++; if (shapool_result !== 40'h0) begin fails++; $display("FAIL middrain_reset_result: got %h expected 0", shapool_result); end
    checks++; if (dut.r_nonce !== 32'h0) begin fails++; $display("FAIL middrain_reset_nonce: got %h expected 0", dut.r_nonce); end
  endtask

  initial begin
    test_reset();
    test_nonce_start();
    test_hit();
    test_overflow();
    test_full_push_pop();
    test_exhaust();
    test_run_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
